dkong3_obj_dma: RTL
===================

// Module: dkong3_obj_dma
// PURPOSE
//  Object-RAM DMA stage, directly upstream of the sprite engine.
//  - On a CPU trigger, requests the CPU bus and copies XFER_LEN bytes of sprite attributes from CPU work RAM into dual-port object RAM (port A).
//  - Writes go to the bank not being displayed, giving double buffering against I_2PSL.
//  - Two cycles per byte; releases the bus when the copy completes.
// PARAMETERS
//  XFER_LEN  384      bytes per transfer; range 1..512
//  SRC_RST   16'h6900 source base register value after reset
//  DST_BASE  9'h000   start offset within the selected 512-byte object RAM bank
// PORTS
//  I_CLK_12M     in   1   system clock; all state changes on the rising edge
//  RST_4L        in   1   reset: asynchronous, active-low
//  I_CPU_DB      in   8   CPU data bus, used for base register writes
//  I_BASE_WRn    in   1   base register write strobe, active-low, one cycle
//  I_BASE_HI     in   1   base register byte select: 1 = high byte, 0 = low byte
//  I_STARTn      in   1   DMA trigger, active-low; falling edge detected
//  I_2PSL        in   1   bank currently displayed by the sprite engine
//  I_BUSAKn      in   1   CPU bus acknowledge, active-low
//  I_SRC_D       in   8   source RAM read data; valid one cycle after address
//  O_BUSRQn      out  1   CPU bus request, active-low
//  O_SRC_A       out  16  source RAM address
//  O_SRC_RDn     out  1   source RAM read strobe, active-low
//  O_OBJ_DMA_A   out  10  object RAM write address
//  O_OBJ_DMA_D   out  8   object RAM write data
//  O_OBJ_DMA_CE  out  1   object RAM write enable, one cycle per byte
//  O_BUSY        out  1   high from trigger acceptance until IDLE is re-entered
//  O_DONE        out  1   one-cycle pulse when the last byte has been written
// BEHAVIOUR
//  Reset (async, RST_4L=0)
//   - FSM goes to IDLE; index = 0; src_base = SRC_RST.
//   - Outputs: O_BUSRQn=1, O_SRC_RDn=1, O_OBJ_DMA_CE=0, O_BUSY=0, O_DONE=0, O_SRC_A=0, O_OBJ_DMA_A=0, O_OBJ_DMA_D=0.
//   - Assertion mid-transfer aborts at once; no partial-byte write is issued.
//  Base register
//   - I_BASE_WRn=0 loads I_CPU_DB into src_base[15:8] (I_BASE_HI=1) or src_base[7:0] (I_BASE_HI=0).
//   - Writes are ignored while O_BUSY=1.
//  Trigger
//   - I_STARTn is registered once; a 1->0 transition seen while in IDLE starts a transfer.
//   - On start: latch bank = ~I_2PSL; copy src_base to a working copy; index = 0; go to REQ.
//   - Triggers seen while busy are dropped, not queued.
//  FSM states: IDLE -> REQ -> READ <-> WRITE -> DONE -> IDLE
//   - REQ: O_BUSRQn=0. Move to READ on the first edge that samples I_BUSAKn=0.
//   - READ: O_SRC_A = base+index, mod 2^16 (wraps); O_SRC_RDn=0. Next state WRITE.
//   - WRITE: I_SRC_D captured at the edge entering WRITE.
//     O_OBJ_DMA_D = captured byte; O_OBJ_DMA_A = {bank, (DST_BASE+index) mod 512}; O_OBJ_DMA_CE=1.
//   - Leaving WRITE (index incremented at that edge):
//     - index was XFER_LEN-1 -> DONE;
//     - else I_BUSAKn=1 -> REQ (pause; index is kept and the transfer resumes at the same byte);
//     - else -> READ.
//   - DONE: O_BUSRQn=1; O_DONE=1 for exactly one cycle; next state IDLE.
//  O_BUSRQn is held low in REQ, READ and WRITE.
//  Timing
//   - Byte k: CE asserted 2k+1 cycles after the first READ cycle.
//   - Total transfer time = 2*XFER_LEN + 2 cycles plus the bus-grant wait.
//  Widths
//   - index is 9 bits.
//   - Destination offset wraps within the latched bank and never spills into the other bank.
// TESTING
//  1. Reset with src_base=6900, I_2PSL=0; pulse I_STARTn; ack after 3 cycles.
//     -> 384 CE pulses; addresses 0x200..0x37F; data = source RAM[0x6900..0x6A7F]; O_DONE pulses once.
//  2. Write base hi=0x12 then lo=0xFF; start.
//     -> first reads at 0x12FF, then 0x1300 (carry propagates).
//  3. DST_BASE=9'h1F0, XFER_LEN=32.
//     -> destination offsets run 1F0..1FF then 000..00F in the same bank; no CE to the opposite bank.
//  4. Deassert I_BUSAKn during the WRITE of byte 10 for 5 cycles.
//     -> FSM returns to REQ; byte 11 is read only after ack; total of 384 writes, none duplicated.
//  5. Second I_STARTn pulse mid-transfer, plus a base register write.
//     -> both ignored; src_base unchanged; exactly one O_DONE.
//  6. Assert RST_4L at byte 100.
//     -> outputs return to reset values asynchronously; O_BUSRQn=1; O_DONE is never pulsed.

Source files
------------

// File: rtl/dkong3_obj_dma.sv
// dkong3_obj_dma: copies sprite attributes from CPU work RAM into the hidden object RAM bank
// Ports: I_CLK_12M/RST_4L clock and async active-low reset; I_CPU_DB/I_BASE_WRn/I_BASE_HI load the
// source base register; I_STARTn falling edge triggers a copy; I_2PSL is the displayed bank;
// I_BUSAKn/O_BUSRQn CPU bus handshake; O_SRC_A/O_SRC_RDn/I_SRC_D source RAM read port;
// O_OBJ_DMA_A/D/CE object RAM port A writes; O_BUSY transfer in progress; O_DONE end-of-copy pulse.
module dkong3_obj_dma #(
  parameter int          XFER_LEN = 384,
  parameter logic [15:0] SRC_RST  = 16'h6900,
  parameter logic [8:0]  DST_BASE = 9'h000
) (
  input  logic        I_CLK_12M,
  input  logic        RST_4L,
  input  logic [7:0]  I_CPU_DB,
  input  logic        I_BASE_WRn,
  input  logic        I_BASE_HI,
  input  logic        I_STARTn,
  input  logic        I_2PSL,
  input  logic        I_BUSAKn,
  input  logic [7:0]  I_SRC_D,
  output logic        O_BUSRQn,
  output logic [15:0] O_SRC_A,
  output logic        O_SRC_RDn,
  output logic [9:0]  O_OBJ_DMA_A,
  output logic [7:0]  O_OBJ_DMA_D,
  output logic        O_OBJ_DMA_CE,
  output logic        O_BUSY,
  output logic        O_DONE
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [8:0] LAST  = 9'(XFER_LEN - 1);
  logic [2:0]  state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [15:0] base_q, base_d, src_q, src_d;
  logic [7:0]  data_q, data_d;
  logic        bank_q, bank_d, start_q, go;
  // start_q holds the previous I_STARTn so a 1->0 step is seen exactly once
  assign go = state_q == IDLE && start_q && !I_STARTn;
  always_comb begin
    state_d = go                ? REQ :
              state_q == REQ    ? (I_BUSAKn ? REQ : READ) :
              state_q == READ   ? WRITE :
              state_q == WRITE  ? (idx_q == LAST ? DONE : I_BUSAKn ? REQ : READ) :
              IDLE;
    idx_d   = go ? 9'd0 : state_q == WRITE ? idx_q + 9'd1 : idx_q;
    base_d  = (I_BASE_WRn || O_BUSY) ? base_q :
              I_BASE_HI ? {I_CPU_DB, base_q[7:0]} : {base_q[15:8], I_CPU_DB};
    src_d   = go ? base_q : src_q;
    bank_d  = go ? ~I_2PSL : bank_q;
    data_d  = state_q == READ ? I_SRC_D : data_q;
  end
  always_ff @(posedge I_CLK_12M or negedge RST_4L)
    if (!RST_4L) begin
      state_q <= IDLE;
      idx_q   <= 9'd0;
      base_q  <= SRC_RST;
      src_q   <= 16'd0;
      data_q  <= 8'd0;
      bank_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      src_q   <= src_d;
      data_q  <= data_d;
      bank_q  <= bank_d;
      start_q <= I_STARTn;
    end
  // outputs decode the registered state so the async reset clears them at once
  assign O_BUSY       = state_q != IDLE;
  assign O_DONE       = state_q == DONE;
  assign O_BUSRQn     = !(state_q == REQ || state_q == READ || state_q == WRITE);
  assign O_SRC_RDn    = state_q != READ;
  assign O_SRC_A      = state_q == READ ? src_q + {7'd0, idx_q} : 16'd0;
  assign O_OBJ_DMA_CE = state_q == WRITE;
  // 9-bit offset sum wraps inside the latched bank
  assign O_OBJ_DMA_A  = O_OBJ_DMA_CE ? {bank_q, DST_BASE + idx_q} : 10'd0;
  assign O_OBJ_DMA_D  = O_OBJ_DMA_CE ? data_q : 8'd0;
endmodule
